// File: rtl/mem_line_pkg.sv
// Shared types and default geometry for the cache-line memory engine.
//   state_t      : engine FSM states
//   DEF_*        : default memory/line geometry
//   line_awidth(): line address width derived from word address width
package mem_line_pkg;

    localparam int unsigned DEF_AWIDTH = 9;
    localparam int unsigned DEF_DWIDTH = 32;
    localparam int unsigned DEF_WORDS  = 4;

    // Line address width: word address minus the word-in-line offset bits.
    function automatic int unsigned line_awidth(input int unsigned awidth, input int unsigned words);
        return awidth - $clog2(words);
    endfunction

    localparam int unsigned DEF_LAWIDTH = line_awidth(DEF_AWIDTH, DEF_WORDS);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        ACCESS,
        HOLD,
        DONE
    } state_t;

endpackage

// File: rtl/mem_line_if.sv
// Interfaces of the cache-line memory engine.
//   mem_line_req_if : cache-side line request (master = cache, slave = engine)
//     req_valid/req_ready/req_wr/req_line_addr/wb_data in, fill_data/done/busy back
//   mem_word_if     : word-wide main-memory port (master = engine, slave = memory)
//     rd_mem/wr_mem/addr_mem/data_mem_out out, data_mem_in/ready_mem back
interface mem_line_req_if
    import mem_line_pkg::*;
#(
    parameter int unsigned AWIDTH = DEF_AWIDTH,
    parameter int unsigned DWIDTH = DEF_DWIDTH,
    parameter int unsigned WORDS  = DEF_WORDS
);
    localparam int unsigned LAWIDTH = line_awidth(AWIDTH, WORDS);
    localparam int unsigned LWIDTH  = WORDS * DWIDTH;

    logic               req_valid;
    logic               req_ready;
    logic               req_wr;
    logic [LAWIDTH-1:0] req_line_addr;
    logic [LWIDTH-1:0]  wb_data;
    logic [LWIDTH-1:0]  fill_data;
    logic               done;
    logic               busy;

    modport master (
        output req_valid, req_wr, req_line_addr, wb_data,
        input  req_ready, fill_data, done, busy
    );

    modport slave (
        input  req_valid, req_wr, req_line_addr, wb_data,
        output req_ready, fill_data, done, busy
    );
endinterface

interface mem_word_if
    import mem_line_pkg::*;
#(
    parameter int unsigned AWIDTH = DEF_AWIDTH,
    parameter int unsigned DWIDTH = DEF_DWIDTH
);
    logic              rd_mem;
    logic              wr_mem;
    logic [AWIDTH-1:0] addr_mem;
    logic [DWIDTH-1:0] data_mem_out;
    logic [DWIDTH-1:0] data_mem_in;
    logic              ready_mem;

    modport master (
        output rd_mem, wr_mem, addr_mem, data_mem_out,
        input  data_mem_in, ready_mem
    );

    modport slave (
        input  rd_mem, wr_mem, addr_mem, data_mem_out,
        output data_mem_in, ready_mem
    );
endinterface

// File: rtl/mem_line_buf.sv
// WORDS x DWIDTH line register with a per-word write enable.
//   clk, reset_n : clock, async active-low clear
//   we, idx      : write word idx with wdata on the rising edge
//   line         : flat packed line, word i in [i*DWIDTH +: DWIDTH]
module mem_line_buf
    import mem_line_pkg::*;
#(
    parameter  int unsigned DWIDTH = DEF_DWIDTH,
    parameter  int unsigned WORDS  = DEF_WORDS,
    localparam int unsigned IWIDTH = $clog2(WORDS)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      we,
    input  logic [IWIDTH-1:0]         idx,
    input  logic [DWIDTH-1:0]         wdata,
    output logic [WORDS*DWIDTH-1:0]   line
);

    // Word-granular capture; unselected words keep their value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            line <= '0;
        end else begin
            for (int unsigned w = 0; w < WORDS; w++) begin
                if (we && (idx == IWIDTH'(w))) begin
                    line[w*DWIDTH +: DWIDTH] <= wdata;
                end
            end
        end
    end

endmodule

// File: rtl/mem_line_engine.sv
// Cache-line engine: serialises one fill or writeback line into per-word
// memory accesses (WAIT_RDY -> ACCESS -> HOLD per word), then pulses done.
//   clk, reset_n : clock, async active-low reset
//   req          : cache-side request port (slave)
//   mem          : word-wide memory port (master)
module mem_line_engine
    import mem_line_pkg::*;
#(
    parameter int unsigned AWIDTH = DEF_AWIDTH,
    parameter int unsigned DWIDTH = DEF_DWIDTH,
    parameter int unsigned WORDS  = DEF_WORDS
) (
    input  logic          clk,
    input  logic          reset_n,
    mem_line_req_if.slave req,
    mem_word_if.master    mem
);

    localparam int unsigned LAWIDTH = line_awidth(AWIDTH, WORDS);
    localparam int unsigned IWIDTH  = $clog2(WORDS);
    localparam int unsigned LWIDTH  = WORDS * DWIDTH;
    localparam logic [IWIDTH-1:0] LAST_IDX = IWIDTH'(WORDS - 1);

    state_t             state;
    state_t             state_nxt;
    logic [IWIDTH-1:0]  idx;
    logic               line_wr;
    logic [LAWIDTH-1:0] line_addr;
    logic [LWIDTH-1:0]  wb_line;
    logic [DWIDTH-1:0]  wb_word;
    logic               accept;
    logic               capture;
    logic               strobe_nxt;

    assign accept     = (state == IDLE) && req.req_valid;
    assign capture    = (state == HOLD) && !line_wr;
    assign strobe_nxt = (state_nxt == ACCESS) || (state_nxt == HOLD);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     if (req.req_valid) state_nxt = WAIT_RDY;
            WAIT_RDY: if (mem.ready_mem) state_nxt = ACCESS;
            ACCESS:   state_nxt = HOLD;
            HOLD:     state_nxt = (idx == LAST_IDX) ? DONE : WAIT_RDY;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Request latch at acceptance and word counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx       <= '0;
            line_wr   <= 1'b0;
            line_addr <= '0;
            wb_line   <= '0;
        end else if (accept) begin
            idx       <= '0;
            line_wr   <= req.req_wr;
            line_addr <= req.req_line_addr;
            wb_line   <= req.wb_data;
        end else if ((state == HOLD) && (idx != LAST_IDX)) begin
            idx <= idx + IWIDTH'(1);
        end
    end

    // Writeback word currently addressed by idx.
    always_comb begin
        wb_word = '0;
        for (int unsigned w = 0; w < WORDS; w++) begin
            if (idx == IWIDTH'(w)) begin
                wb_word = wb_line[w*DWIDTH +: DWIDTH];
            end
        end
    end

    // Registered status and memory-port outputs, decoded from the next state.
    // Address and write data load on entry to ACCESS and hold through HOLD.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req.req_ready    <= 1'b1;
            req.busy         <= 1'b0;
            req.done         <= 1'b0;
            mem.rd_mem       <= 1'b0;
            mem.wr_mem       <= 1'b0;
            mem.addr_mem     <= '0;
            mem.data_mem_out <= '0;
        end else begin
            req.req_ready <= (state_nxt == IDLE);
            req.busy      <= (state_nxt != IDLE);
            req.done      <= (state_nxt == DONE);
            mem.rd_mem    <= strobe_nxt && !line_wr;
            mem.wr_mem    <= strobe_nxt && line_wr;
            if ((state == WAIT_RDY) && (state_nxt == ACCESS)) begin
                mem.addr_mem <= {line_addr, idx};
                if (line_wr) begin
                    mem.data_mem_out <= wb_word;
                end
            end
        end
    end

    // Fill line assembly; the memory returns data registered on the negedge.
    mem_line_buf #(
        .DWIDTH (DWIDTH),
        .WORDS  (WORDS)
    ) u_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (capture),
        .idx     (idx),
        .wdata   (mem.data_mem_in),
        .line    (req.fill_data)
    );

endmodule

// File: tb/tb_mem_line_engine.sv
// Directed bench for mem_line_engine with a negedge-registered memory model
// and a scoreboard of expected strobes and completions.
module tb_mem_line_engine;
    import mem_line_pkg::*;

    localparam int unsigned AW  = 9;
    localparam int unsigned DW  = 32;
    localparam int unsigned WD  = 4;
    localparam int unsigned LAW = AW - $clog2(WD);
    localparam int unsigned LW  = WD * DW;

    typedef struct {
        int          kind;   // 0 read strobe, 1 write strobe, 2 done
        int          addr;
        logic [DW-1:0] word;
        logic [LW-1:0] line;
        int          rel;    // cycle after acceptance
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic stall = 1'b0;
    always #5 clk = ~clk;

    mem_line_req_if #(.AWIDTH(AW), .DWIDTH(DW), .WORDS(WD)) rq ();
    mem_word_if     #(.AWIDTH(AW), .DWIDTH(DW))             mw ();

    mem_line_engine #(.AWIDTH(AW), .DWIDTH(DW), .WORDS(WD)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (rq),
        .mem     (mw)
    );

    // Memory model: address/data registered on the falling edge.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    assign mw.ready_mem = !stall && !mw.rd_mem && !mw.wr_mem;
    always @(negedge clk) begin
        if (mw.rd_mem) mw.data_mem_in <= mem[mw.addr_mem];
        if (mw.wr_mem) mem[mw.addr_mem] <= mw.data_mem_out;
    end

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int addr0_hits = 0;
    exp_t sb[$];

    function automatic void chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endfunction

    function automatic void fail(input string name, input int info);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: info %0d (cycle %0d)", name, info, cyc);
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset_n && rq.req_valid && rq.req_ready) acc_cyc <= cyc + 1;
    end

    // Monitor: pops the scoreboard on each strobe start and each done.
    logic prev_strobe = 1'b0;
    logic prev_done = 1'b0;
    int   slen = 0;
    exp_t e;
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_strobe = 1'b0;
            prev_done   = 1'b0;
            slen        = 0;
        end else begin
            if ((mw.rd_mem || mw.wr_mem) && !prev_strobe) begin
                if (mw.addr_mem == '0) addr0_hits++;
                if (sb.size() == 0) begin
                    fail("unexpected_strobe", int'(mw.addr_mem));
                end else begin
                    e = sb.pop_front();
                    chk("strobe_kind", LW'(mw.wr_mem), LW'(e.kind));
                    chk("strobe_addr", LW'(mw.addr_mem), LW'(e.addr));
                    chk("strobe_cycle", LW'(cyc - acc_cyc + 1), LW'(e.rel));
                    if (e.kind == 1) chk("wr_data", LW'(mw.data_mem_out), LW'(e.word));
                end
            end
            if (mw.rd_mem || mw.wr_mem) begin
                slen++;
            end else if (prev_strobe) begin
                chk("strobe_len", LW'(slen), LW'(2));
                slen = 0;
            end
            if (prev_done) chk("done_pulse", LW'(rq.done), LW'(0));
            if (rq.done) begin
                if (sb.size() == 0) begin
                    fail("unexpected_done", 0);
                end else begin
                    e = sb.pop_front();
                    chk("done_kind", LW'(2), LW'(e.kind));
                    chk("done_cycle", LW'(cyc - acc_cyc + 1), LW'(e.rel));
                    chk("fill_data", rq.fill_data, e.line);
                end
            end
            prev_strobe = mw.rd_mem || mw.wr_mem;
            prev_done   = rq.done;
        end
    end

    // Push expected strobes for words [0, nwords) and optionally the done.
    task automatic expect_line(input logic wr, input int line, input logic [LW-1:0] wb,
                               input logic [LW-1:0] fill_exp, input int stall_word,
                               input int stall_len, input int nwords, input bit with_done);
        exp_t x;
        for (int w = 0; w < nwords; w++) begin
            x.kind = wr ? 1 : 0;
            x.addr = line * int'(WD) + w;
            x.word = wb[w*DW +: DW];
            x.line = '0;
            x.rel  = 3 * w + 2 + ((w >= stall_word) ? stall_len : 0);
            sb.push_back(x);
        end
        if (with_done) begin
            x.kind = 2;
            x.addr = 0;
            x.word = '0;
            x.line = fill_exp;
            x.rel  = 13 + ((stall_word < int'(WD)) ? stall_len : 0);
            sb.push_back(x);
        end
    endtask

    // Issue one request; returns 1 time unit after the acceptance edge.
    task automatic issue(input logic wr, input int line, input logic [LW-1:0] wb);
        int t = 0;
        @(negedge clk);
        while (!rq.req_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!rq.req_ready) fail("ready_timeout", t);
        rq.req_valid     = 1'b1;
        rq.req_wr        = wr;
        rq.req_line_addr = LAW'(line);
        rq.wb_data       = wb;
        @(posedge clk);
        #1;
        rq.req_valid     = 1'b0;
        rq.req_wr        = ~wr;
        rq.req_line_addr = ~rq.req_line_addr;
        rq.wb_data       = ~wb;
    endtask

    task automatic drain(input int budget);
        int t = 0;
        while (sb.size() != 0 && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            fail("drain_timeout", sb.size());
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    localparam logic [LW-1:0] LINE_A  = 128'h000000A3_000000A2_000000A1_000000A0;
    localparam logic [LW-1:0] LINE_D  = 128'hDEAD0003_DEAD0002_DEAD0001_DEAD0000;
    localparam logic [LW-1:0] LINE_B  = 128'hBEEF0003_BEEF0002_BEEF0001_BEEF0000;

    initial begin
        int low;
        int a1;
        int a2;
        rq.req_valid     = 1'b0;
        rq.req_wr        = 1'b0;
        rq.req_line_addr = '0;
        rq.wb_data       = '0;
        for (int i = 0; i < (1 << AW); i++) mem[i] <= DW'(32'h0BAD0000 + i);
        for (int i = 0; i < 4; i++) mem[20 + i] <= DW'(32'hA0 + i);
        for (int i = 0; i < 4; i++) mem[8 + i] <= DW'(32'h55550008 + i);

        // Reset over three edges.
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_rd_mem", LW'(mw.rd_mem), LW'(0));
        chk("rst_wr_mem", LW'(mw.wr_mem), LW'(0));
        chk("rst_done", LW'(rq.done), LW'(0));
        chk("rst_busy", LW'(rq.busy), LW'(0));
        chk("rst_addr", LW'(mw.addr_mem), LW'(0));
        chk("rst_fill", rq.fill_data, LW'(0));
        chk("rst_ready", LW'(rq.req_ready), LW'(1));

        // Fill of line 5 (addresses 20..23).
        expect_line(1'b0, 5, '0, LINE_A, 99, 0, 4, 1'b1);
        issue(1'b0, 5, '0);
        drain(60);

        // Top-of-memory writeback, then fill back; fill_data untouched by the writeback.
        expect_line(1'b1, 127, LINE_D, LINE_A, 99, 0, 4, 1'b1);
        issue(1'b1, 127, LINE_D);
        drain(60);
        expect_line(1'b0, 127, '0, LINE_D, 99, 0, 4, 1'b1);
        issue(1'b0, 127, '0);
        drain(60);
        chk("no_addr0_access", LW'(addr0_hits), LW'(0));

        // Back-to-back with req_valid held high.
        expect_line(1'b0, 5, '0, LINE_A, 99, 0, 4, 1'b1);
        expect_line(1'b0, 127, '0, LINE_D, 99, 0, 4, 1'b1);
        @(negedge clk);
        rq.req_valid     = 1'b1;
        rq.req_wr        = 1'b0;
        rq.req_line_addr = LAW'(5);
        @(posedge clk);
        #1;
        a1 = acc_cyc;
        rq.req_line_addr = LAW'(127);
        low = 0;
        @(negedge clk);
        while (!rq.req_ready && low < 100) begin
            low++;
            @(negedge clk);
        end
        chk("b2b_ready_low", LW'(low), LW'(13));
        @(posedge clk);
        #1;
        a2 = acc_cyc;
        rq.req_valid = 1'b0;
        chk("b2b_accept_gap", LW'(a2 - a1), LW'(14));
        drain(60);

        // Reset during HOLD of word 1 of a writeback to line 2.
        expect_line(1'b1, 2, LINE_B, '0, 99, 0, 2, 1'b0);
        issue(1'b1, 2, LINE_B);
        repeat (5) @(posedge clk);
        #2;
        chk("hold_strobe", LW'(mw.wr_mem), LW'(1));
        reset_n = 1'b0;
        #1;
        chk("mid_rst_wr_mem", LW'(mw.wr_mem), LW'(0));
        chk("mid_rst_rd_mem", LW'(mw.rd_mem), LW'(0));
        chk("mid_rst_busy", LW'(rq.busy), LW'(0));
        chk("mid_rst_ready", LW'(rq.req_ready), LW'(1));
        chk("mid_rst_addr", LW'(mw.addr_mem), LW'(0));
        chk("mid_rst_fill", rq.fill_data, LW'(0));
        chk("mid_rst_sb_empty", LW'(sb.size()), LW'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        chk("mem8", LW'(mem[8]), LW'(32'hBEEF0000));
        chk("mem9", LW'(mem[9]), LW'(32'hBEEF0001));
        chk("mem10", LW'(mem[10]), LW'(32'h5555000A));
        chk("mem11", LW'(mem[11]), LW'(32'h5555000B));

        // Five-cycle stall in WAIT_RDY of word 2.
        expect_line(1'b0, 5, '0, LINE_A, 2, 5, 4, 1'b1);
        issue(1'b0, 5, '0);
        repeat (6) @(posedge clk);
        #1;
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_no_strobe", LW'(mw.rd_mem || mw.wr_mem), LW'(0));
        end
        @(posedge clk);
        #1;
        stall = 1'b0;
        drain(60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
